// File: rtl/kernel_weight_bank_if.sv
// Weight-load port of the kernel weight bank: load control, the weight
// beat stream and the load status flags, grouped so a driver and the bank
// can be connected through a single port.
interface kernel_weight_bank_if #(
  parameter int DW = 32,
  parameter int KW = 1
);
  logic          iLoadStart;
  logic [KW-1:0] iKerSel;
  logic          iValid;
  logic          oReady;
  logic [DW-1:0] iWeight;
  logic          iCommit;
  logic          iAbort;
  logic          oFull;
  logic          oDone;
  logic          oBusy;

  // Driver side (stimulus / upstream loader).
  modport master (
    output iLoadStart, iKerSel, iValid, iWeight, iCommit, iAbort,
    input  oReady, oFull, oDone, oBusy
  );

  // Bank side.
  modport slave (
    input  iLoadStart, iKerSel, iValid, iWeight, iCommit, iAbort,
    output oReady, oFull, oDone, oBusy
  );
endinterface

// File: rtl/kernel_weight_bank.sv
// Kernel weight bank: NKER active KSIZE x KSIZE kernels for the conv MAC
// array. Weights stream into one shadow buffer and are committed to a
// kernel slot in a single cycle, so the active slot never holds a
// partially loaded kernel. A registered flattened bus presents the
// selected kernel; a registered readback port serves debug access.
//
// Handshake: a weight beat transfers on a rising edge where iValid and
// oReady are both high. oReady is high only in LOAD and does not depend
// on iValid; iValid may drop at any time, stalling the load indefinitely.
// iAbort in the same cycle as a beat discards that beat.
module kernel_weight_bank #(
  parameter int DW    = 32,
  parameter int KSIZE = 5,
  parameter int NKER  = 2,
  parameter int KW    = 1,
  parameter int AW    = 5
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  kernel_weight_bank_if.slave       ldIf,
  input  logic [KW-1:0]             iActSel,
  output logic [KSIZE*KSIZE*DW-1:0] oWeights,
  input  logic [KW-1:0]             iRdSel,
  input  logic [AW-1:0]             iRdAddr,
  output logic [DW-1:0]             oRdData,
  output logic [1:0]                oState
);
  localparam int          NTAP   = KSIZE * KSIZE;
  localparam logic [31:0] NKER_U = 32'(NKER);
  localparam logic [31:0] NTAP_U = 32'(NTAP);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, COMMIT} state_t;

  state_t        state, stateNext;
  logic          busy;
  logic [AW-1:0] count;
  logic [KW-1:0] slot;
  logic [DW-1:0] shadow [NTAP];
  logic [DW-1:0] active [NKER][NTAP];

  logic startOk, beat, lastBeat, actOk, rdOk;

  assign startOk  = ldIf.iLoadStart && (32'(ldIf.iKerSel) < NKER_U);
  assign beat     = (state == LOAD) && ldIf.iValid && !ldIf.iAbort;
  assign lastBeat = beat && (count == AW'(NTAP - 1));
  assign actOk    = 32'(iActSel) < NKER_U;
  assign rdOk     = (32'(iRdSel) < NKER_U) && (32'(iRdAddr) < NTAP_U);

  assign ldIf.oBusy = busy;
  assign oState     = state;

  // Next-state and status decode; abort wins over commit and the final beat.
  always_comb begin
    stateNext   = state;
    ldIf.oReady = 1'b0;
    ldIf.oFull  = 1'b0;
    ldIf.oDone  = 1'b0;
    case (state)
      IDLE: begin
        if (startOk) stateNext = LOAD;
      end
      LOAD: begin
        ldIf.oReady = 1'b1;
        if (ldIf.iAbort)   stateNext = IDLE;
        else if (lastBeat) stateNext = FULL;
      end
      FULL: begin
        ldIf.oFull = 1'b1;
        if (ldIf.iAbort)       stateNext = IDLE;
        else if (ldIf.iCommit) stateNext = COMMIT;
      end
      COMMIT: begin
        ldIf.oDone = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register with the busy flag registered alongside it.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE);
    end
  end

  // Tap counter, destination slot latch and shadow buffer fill.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      count <= '0;
      slot  <= '0;
      for (int t = 0; t < NTAP; t++) shadow[t] <= '0;
    end else begin
      if ((state == IDLE) && startOk) begin
        count <= '0;
        slot  <= ldIf.iKerSel;
      end
      if (beat) begin
        shadow[count] <= ldIf.iWeight;
        count         <= count + AW'(1);
      end
    end
  end

  // Atomic copy of the whole shadow buffer into the destination slot.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int k = 0; k < NKER; k++)
        for (int t = 0; t < NTAP; t++) active[k][t] <= '0;
    end else if (state == COMMIT) begin
      for (int t = 0; t < NTAP; t++) active[slot][t] <= shadow[t];
    end
  end

  // Registered kernel bus and readback; out-of-range selects read as zero.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oWeights <= '0;
      oRdData  <= '0;
    end else begin
      for (int t = 0; t < NTAP; t++)
        oWeights[t*DW +: DW] <= actOk ? active[iActSel][t] : '0;
      oRdData <= rdOk ? active[iRdSel][iRdAddr] : '0;
    end
  end
endmodule
